// File: rtl/bit_serial_subtractor.sv
// LSB-first bit-serial subtractor: diff = a - b - bin, one bit per clock.
// start/busy/done handshake; result registers only change on the final bit.
module bit_serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]  sa, sb, wr;
  logic [N-1:0]  sa_nxt, sb_nxt, wr_nxt;
  logic          br, br_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          d;
  logic          last;
  logic          load;
  logic          step;

  assign d    = sa[0] ^ sb[0] ^ br;
  assign last = (cnt == CW'(N - 1));
  assign load = (state == IDLE) && start;
  assign step = (state == SHIFT);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift datapath; width-generic form also covers N = 1.
  always_comb begin
    sa_nxt = sa;
    sb_nxt = sb;
    wr_nxt = wr;
    br_nxt = br;
    cnt_nxt = cnt;
    if (load) begin
      sa_nxt = a;
      sb_nxt = b;
      br_nxt = bin;
      cnt_nxt = '0;
    end else if (step) begin
      sa_nxt = sa >> 1;
      sb_nxt = sb >> 1;
      wr_nxt = wr >> 1;
      wr_nxt[N-1] = d;
      br_nxt = (~sa[0] & sb[0])
             | (~(sa[0] ^ sb[0]) & br);
      cnt_nxt = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sa  <= '0;
      sb  <= '0;
      wr  <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else begin
      sa  <= sa_nxt;
      sb  <= sb_nxt;
      wr  <= wr_nxt;
      br  <= br_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Results commit only on the last bit, so they never show partial sums.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (step && last) begin
      diff <= wr_nxt;
      bout <= br_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor (N = 4).
// Directed scenarios plus exhaustive/random ops against an arithmetic model.
module tb_bit_serial_subtractor;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic [N-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  bit_serial_subtractor #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .diff (diff),
    .bout (bout),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  function automatic logic [N:0] model(input int ia, input int ib, input int ibin);
    int t;
    t = ia - ib - ibin;
    model = {(t < 0), N'(t & ((1 << N) - 1))};
  endfunction

  // Drive one op; report result, latency in cycles, pulse shape, hold behaviour.
  task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                        input logic ibin, output logic [N-1:0] od,
                        output logic ob, output int lat,
                        output logic one_pulse, output logic held);
    logic [N-1:0] pd;
    logic pb;
    pd = diff;
    pb = bout;
    held = 1'b1;
    lat = -1;
    @(negedge clk);
    a = ia;
    b = ib;
    bin = ibin;
    start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      a = N'($urandom);
      b = N'($urandom);
      bin = 1'($urandom);
      if (done) begin
        lat = i;
        break;
      end
      if (diff !== pd || bout !== pb) held = 1'b0;
    end
    od = diff;
    ob = bout;
    @(negedge clk);
    one_pulse = !done && !busy;
  endtask

  task automatic test_reset;
    logic [N-1:0] od;
    logic ob, p, h;
    int lat;
    run_op(4'b0000, 4'b0001, 1'b0, od, ob, lat, p, h);
    @(posedge clk);
    #25;
    rst = 1'b0;
    #1;
    checks++;
    if (diff !== 4'b0000 || bout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: diff=%b bout=%b busy=%b done=%b, want 0000 0 0 0",
               diff, bout, busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed;
    logic [N-1:0] od;
    logic ob, p, h;
    int lat;
    run_op(4'b0011, 4'b1011, 1'b0, od, ob, lat, p, h);
    checks++;
    if (od !== 4'b1000 || ob !== 1'b1) begin
      errors++;
      $display("FAIL dir_3m11: got %b/%b want 1000/1", od, ob);
    end
    checks++;
    if (lat !== N + 1) begin
      errors++;
      $display("FAIL latency: got %0d want %0d", lat, N + 1);
    end
    checks++;
    if (p !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: done/busy not low after one cycle (%b)", p);
    end
    run_op(4'b0011, 4'b0001, 1'b0, od, ob, lat, p, h);
    checks++;
    if (od !== 4'b0010 || ob !== 1'b0) begin
      errors++;
      $display("FAIL dir_3m1: got %b/%b want 0010/0", od, ob);
    end
    checks++;
    if (h !== 1'b1) begin
      errors++;
      $display("FAIL hold: diff/bout changed during SHIFT (%b)", h);
    end
    run_op(4'b0000, 4'b0000, 1'b1, od, ob, lat, p, h);
    checks++;
    if (od !== 4'b1111 || ob !== 1'b1) begin
      errors++;
      $display("FAIL dir_0m0b: got %b/%b want 1111/1", od, ob);
    end
  endtask

  task automatic test_back_to_back;
    int t1, t2, n;
    logic [N-1:0] d1, d2;
    logic b1, b2;
    t1 = -1;
    t2 = -1;
    n = 0;
    d1 = 'x;
    d2 = 'x;
    b1 = 1'bx;
    b2 = 1'bx;
    @(negedge clk);
    a = 4'b1111;
    b = 4'b1111;
    bin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    a = 4'b1000;
    b = 4'b0001;
    for (int i = 1; i <= 30; i++) begin
      if (done) begin
        if (n == 0) begin
          t1 = i;
          d1 = diff;
          b1 = bout;
        end else begin
          t2 = i;
          d2 = diff;
          b2 = bout;
          start = 1'b0;
        end
        n++;
        if (n == 2) break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (d1 !== 4'b0000 || b1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_op1: got %b/%b want 0000/0", d1, b1);
    end
    checks++;
    if (d2 !== 4'b0111 || b2 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_op2: got %b/%b want 0111/0", d2, b2);
    end
    checks++;
    if (t2 - t1 !== N + 2 || t1 < 0 || t2 < 0) begin
      errors++;
      $display("FAIL b2b_period: got %0d want %0d", t2 - t1, N + 2);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat;
    int extra;
    lat = -1;
    extra = 0;
    @(negedge clk);
    a = 4'b0011;
    b = 4'b1011;
    bin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'b1111;
    b = 4'b0000;
    bin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat < 0 || diff !== 4'b1000 || bout !== 1'b1) begin
      errors++;
      $display("FAIL ignore_start: got %b/%b want 1000/1", diff, bout);
    end
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL ignore_no_op: busy for %0d cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    int stale;
    logic [N-1:0] od;
    logic ob, p, h;
    int lat;
    stale = 0;
    @(negedge clk);
    a = 4'b1111;
    b = 4'b0000;
    bin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #10;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'b0000 || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b diff=%b bout=%b want 0 0 0000 0",
               busy, done, diff, bout);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (done || busy) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL stale_done: %0d active cycles, want 0", stale);
    end
    run_op(4'b0101, 4'b0110, 1'b1, od, ob, lat, p, h);
    checks++;
    if (od !== 4'b1110 || ob !== 1'b1) begin
      errors++;
      $display("FAIL reset_fresh: got %b/%b want 1110/1", od, ob);
    end
  endtask

  task automatic test_exhaustive;
    logic [N-1:0] od;
    logic ob, p, h;
    int lat;
    logic [N:0] exp;
    int ia, ib, ibin;
    for (int k = 0; k < 512 + 200; k++) begin
      if (k < 512) begin
        ia = k[3:0];
        ib = k[7:4];
        ibin = k[8];
      end else begin
        ia = int'($urandom_range(15, 0));
        ib = int'($urandom_range(15, 0));
        ibin = int'($urandom_range(1, 0));
      end
      exp = model(ia, ib, ibin);
      run_op(N'(ia), N'(ib), 1'(ibin), od, ob, lat, p, h);
      checks++;
      if (od !== exp[N-1:0] || ob !== exp[N] || lat !== N + 1 || p !== 1'b1) begin
        errors++;
        $display("FAIL op %0d-%0d-%0d: got %b/%b lat %0d, want %b/%b lat %0d",
                 ia, ib, ibin, od, ob, lat, exp[N-1:0], exp[N], N + 1);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
